// File: rtl/fpu_out_pkg.sv
// fpu_out_pkg: shared widths, ID field helpers and pipe indices for the FPU output arbiter
package fpu_out_pkg;
  localparam int ID_W = 10;
  localparam int DIV = 2;
  localparam int MUL = 1;
  localparam int ADD = 0;
  typedef logic [ID_W-1:0] id_t;
  function automatic logic [7:0] id_dst(id_t id);
    return id[9:2];
  endfunction
  function automatic logic [1:0] id_thr(id_t id);
    return id[1:0];
  endfunction
endpackage

// File: rtl/fpu_out_arb_if.sv
// fpu_out_arb_if: pipe result inputs, CPX credit return and arbiter request outputs
interface fpu_out_arb_if;
  import fpu_out_pkg::*;
  logic       div_req, mul_req, add_req;
  id_t        div_id, mul_id, add_id;
  logic       cpx_fp_gnt;
  logic [7:0] fp_cpx_req_cq;
  logic [1:0] req_thread;
  logic [2:0] dest_rdy;
  logic       div_hold_full, mul_hold_full, add_hold_full;
  logic [1:0] err;
  modport master (
    output div_req, div_id, mul_req, mul_id, add_req, add_id, cpx_fp_gnt,
    input  fp_cpx_req_cq, req_thread, dest_rdy, div_hold_full, mul_hold_full, add_hold_full, err
  );
  modport slave (
    input  div_req, div_id, mul_req, mul_id, add_req, add_id, cpx_fp_gnt,
    output fp_cpx_req_cq, req_thread, dest_rdy, div_hold_full, mul_hold_full, add_hold_full, err
  );
endinterface

// File: rtl/fpu_out_hold.sv
// fpu_out_hold: 1-entry result hold; presents the held entry (or the incoming one) as the candidate
module fpu_out_hold
  import fpu_out_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  id_t  id_in,
  input  logic win,
  output logic full,
  output logic cand_v,
  output id_t  cand_id,
  output logic ovf
);
  logic valid_q, valid_d;
  id_t  id_q, id_d;
  logic load;
  assign cand_v  = valid_q | req;
  assign cand_id = valid_q ? id_q : id_in;
  assign full    = valid_q;
  always_comb begin
    load    = req & (valid_q ? win : ~win);
    valid_d = load | (valid_q & ~win);
    id_d    = load ? id_in : id_q;
    ovf     = valid_q & ~win & req;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
    end
endmodule

// File: rtl/fpu_out_arb.sv
// fpu_out_arb: credit-based CPX request arbiter over div/mul/add result pipes
module fpu_out_arb
  import fpu_out_pkg::*;
#(
  parameter int CREDITS    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic          rclk,
  input logic          arst_l,
  fpu_out_arb_if.slave bus
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [2:0] req, cv, full, ovf, win;
  id_t        rid [3];
  id_t        cid [3];
  logic       div_win, mul_win, add_win, arb_en, mask, issue, cred_ovf;
  id_t        sel;
  logic [CW-1:0] credit_q, credit_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rr_q, rr_d;
  logic [7:0]    cq_q, cq_d;
  logic [1:0]    thr_q, thr_d, err_q, err_d;
  logic [2:0]    dest_q, dest_d;
  assign req[DIV] = bus.div_req;
  assign req[MUL] = bus.mul_req;
  assign req[ADD] = bus.add_req;
  assign rid[DIV] = bus.div_id;
  assign rid[MUL] = bus.mul_id;
  assign rid[ADD] = bus.add_id;
  assign win      = {div_win, mul_win, add_win};
  for (genvar i = 0; i < 3; i++) begin : g_hold
    fpu_out_hold u_hold (
      .clk(rclk), .rst_n(arst_l), .req(req[i]), .id_in(rid[i]), .win(win[i]),
      .full(full[i]), .cand_v(cv[i]), .cand_id(cid[i]), .ovf(ovf[i])
    );
  end
  always_comb begin
    arb_en   = credit_q != '0;
    mask     = starve_q == SW'(STARVE_MAX);
    div_win  = arb_en & cv[DIV] & ~mask;
    mul_win  = arb_en & ~div_win & cv[MUL] & (~cv[ADD] | ~rr_q);
    add_win  = arb_en & ~div_win & cv[ADD] & (~cv[MUL] | rr_q);
    issue    = div_win | mul_win | add_win;
    sel      = div_win ? cid[DIV] : mul_win ? cid[MUL] : cid[ADD];
    cq_d     = issue ? id_dst(sel) : '0;
    thr_d    = issue ? id_thr(sel) : '0;
    dest_d   = {div_win, mul_win, add_win};
    rr_d     = rr_q ^ (mul_win | add_win);
    // a masked arbitration hands the slot to add/mul and restarts the divide streak
    starve_d = (mul_win | add_win | ~(cv[MUL] | cv[ADD]) | (arb_en & mask)) ? '0 :
               div_win ? starve_q + 1'b1 : starve_q;
    cred_ovf = bus.cpx_fp_gnt & ~issue & (credit_q == CW'(CREDITS));
    credit_d = (issue & ~bus.cpx_fp_gnt) ? credit_q - 1'b1 :
               (bus.cpx_fp_gnt & ~issue & ~cred_ovf) ? credit_q + 1'b1 : credit_q;
    err_d    = err_q | {cred_ovf, |ovf};
  end
  always_ff @(posedge rclk or negedge arst_l)
    if (!arst_l) begin
      credit_q <= CW'(CREDITS);
      starve_q <= '0;
      rr_q     <= 1'b0;
      cq_q     <= '0;
      thr_q    <= '0;
      dest_q   <= '0;
      err_q    <= '0;
    end else begin
      credit_q <= credit_d;
      starve_q <= starve_d;
      rr_q     <= rr_d;
      cq_q     <= cq_d;
      thr_q    <= thr_d;
      dest_q   <= dest_d;
      err_q    <= err_d;
    end
  assign bus.fp_cpx_req_cq = cq_q;
  assign bus.req_thread    = thr_q;
  assign bus.dest_rdy      = dest_q;
  assign bus.div_hold_full = full[DIV];
  assign bus.mul_hold_full = full[MUL];
  assign bus.add_hold_full = full[ADD];
  assign bus.err           = err_q;
endmodule

// File: tb/tb_fpu_out_arb.sv
// tb_fpu_out_arb: directed scenarios plus random traffic against a cycle-level reference model
module tb_fpu_out_arb;
  localparam int CRED = 2;
  localparam int SMAX = 4;
  logic rclk = 1'b0;
  logic arst_l = 1'b0;
  always #5 rclk = ~rclk;
  fpu_out_arb_if bus();
  fpu_out_arb #(.CREDITS(CRED), .STARVE_MAX(SMAX)) dut (.rclk(rclk), .arst_l(arst_l), .bus(bus.slave));
  int total = 0;
  int bad = 0;
  int credit, rr, starve;
  bit hv [3];
  logic [9:0] hid [3];
  logic [1:0] merr;
  logic [7:0] e_cq;
  logic [1:0] e_thr;
  logic [2:0] e_dest;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(bit d, logic [9:0] di, bit m, logic [9:0] mi, bit a, logic [9:0] ai, bit g);
    bus.div_req = d; bus.div_id = di;
    bus.mul_req = m; bus.mul_id = mi;
    bus.add_req = a; bus.add_id = ai;
    bus.cpx_fp_gnt = g;
  endtask

  task automatic mreset();
    credit = CRED; rr = 0; starve = 0; merr = 0;
    e_cq = 0; e_thr = 0; e_dest = 0;
    for (int p = 0; p < 3; p++) begin hv[p] = 0; hid[p] = 0; end
  endtask

  task automatic check_outs(string pre);
    check({pre, "_cq"}, 32'(bus.fp_cpx_req_cq), 32'(e_cq));
    check({pre, "_thr"}, 32'(bus.req_thread), 32'(e_thr));
    check({pre, "_dest"}, 32'(bus.dest_rdy), 32'(e_dest));
    check({pre, "_full"}, 32'({bus.div_hold_full, bus.mul_hold_full, bus.add_hold_full}),
          32'({hv[2], hv[1], hv[0]}));
    check({pre, "_err"}, 32'(bus.err), 32'(merr));
  endtask

  task automatic do_reset();
    #2 arst_l = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 mreset();
    check_outs("rst");
    @(posedge rclk); #1 arst_l = 1'b1;
  endtask

  // one clock: model the decision from the current inputs, then compare registered outputs
  task automatic cycle();
    bit rq [3];
    logic [9:0] ri [3];
    bit cv [3];
    logic [9:0] ci [3];
    logic [9:0] t;
    int w;
    bit mask, ma, g;
    rq[2] = bus.div_req; rq[1] = bus.mul_req; rq[0] = bus.add_req;
    ri[2] = bus.div_id;  ri[1] = bus.mul_id;  ri[0] = bus.add_id;
    g = bus.cpx_fp_gnt;
    for (int p = 0; p < 3; p++) begin
      cv[p] = hv[p] | rq[p];
      ci[p] = hv[p] ? hid[p] : ri[p];
    end
    w = -1;
    mask = (starve == SMAX);
    if (credit > 0) begin
      if (cv[2] && !mask) w = 2;
      else if (cv[1] && cv[0]) w = rr ? 0 : 1;
      else if (cv[1]) w = 1;
      else if (cv[0]) w = 0;
    end
    ma = cv[1] || cv[0];
    if (w == 0 || w == 1 || !ma || (credit > 0 && mask)) starve = 0;
    else if (w == 2) starve++;
    if (w == 0 || w == 1) rr = 1 - rr;
    for (int p = 0; p < 3; p++) begin
      if (w == p) begin
        if (hv[p]) begin hv[p] = rq[p]; if (rq[p]) hid[p] = ri[p]; end
      end else if (rq[p]) begin
        if (hv[p]) merr[0] = 1'b1;
        else begin hv[p] = 1; hid[p] = ri[p]; end
      end
    end
    if (w >= 0 && !g) credit--;
    else if (g && w < 0) begin
      if (credit == CRED) merr[1] = 1'b1;
      else credit++;
    end
    if (w >= 0) begin
      t = ci[w];
      e_cq = t[9:2]; e_thr = t[1:0]; e_dest = 3'(1 << w);
    end else begin
      e_cq = 0; e_thr = 0; e_dest = 0;
    end
    @(posedge rclk); #1;
    check_outs("cyc");
  endtask

  logic [2:0] exp2 [4] = '{3'b010, 3'b001, 3'b010, 3'b001};
  logic [2:0] exp3 [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b100};

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    mreset();
    @(posedge rclk); #1;
    do_reset();
    // single divide result, one-cycle latency
    drive(1, 10'h3F6, 0, 0, 0, 0, 0);
    cycle();
    check("tp1_cq", 32'(bus.fp_cpx_req_cq), 32'h0FD);
    check("tp1_thr", 32'(bus.req_thread), 32'h2);
    check("tp1_dest", 32'(bus.dest_rdy), 32'h4);
    drive(0, 0, 0, 0, 0, 0, 1);
    cycle();
    // mul/add alternation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, !hv[1], 10'(100 + i), !hv[0], 10'(200 + i), 1);
      cycle();
      check("tp2_dest", 32'(bus.dest_rdy), 32'(exp2[i]));
    end
    // starvation guard
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(!hv[2], 10'(300 + i), !hv[1], 10'(400 + i), !hv[0], 10'(500 + i), 1);
      cycle();
      check("tp3_dest", 32'(bus.dest_rdy), 32'(exp3[i]));
    end
    // credit exhaustion
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 10'(12 + i), 0, 0, 0, 0, 0);
      cycle();
    end
    check("tp4_hold", 32'(bus.div_hold_full), 32'h1);
    check("tp4_idle", 32'(bus.dest_rdy), 32'h0);
    drive(0, 0, 0, 0, 0, 0, 1);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();
    check("tp4_issue", 32'(bus.dest_rdy), 32'h4);
    check("tp4_thr", 32'(bus.req_thread), 32'h2);
    // hold overflow
    do_reset();
    drive(0, 0, 1, 10'h111, 1, 10'h2A5, 1);
    cycle();
    drive(1, 10'h0F0, 0, 0, 1, 10'h3C3, 1);
    cycle();
    check("tp5_err", 32'(bus.err), 32'h1);
    drive(0, 0, 0, 0, 0, 0, 1);
    cycle();
    check("tp5_a1", 32'(bus.fp_cpx_req_cq), 32'h0A9);
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();
    check("tp5_drop", 32'(bus.dest_rdy), 32'h0);
    // credit overflow
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    cycle();
    check("tp6_err", 32'(bus.err), 32'h2);
    // random traffic with a mid-run reset
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      drive(($urandom_range(3) == 0) && (!hv[2] || $urandom_range(31) == 0), 10'($urandom),
            ($urandom_range(1) == 0) && (!hv[1] || $urandom_range(31) == 0), 10'($urandom),
            ($urandom_range(1) == 0) && (!hv[0] || $urandom_range(31) == 0), 10'($urandom),
            ($urandom_range(1) == 0) && (credit < CRED || $urandom_range(31) == 0));
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
